ram_queue_arbiter: RTL

// Single-clock controller that turns the shared-address DC_RAM into a circular queue.

---
 rtl/ram_queue_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ram_queue_arbiter.sv
// rtl/ram_queue_arbiter.sv - circular queue controller over a shared-address single-port RAM
// Arbitrates push and pop for the one address bus and sequences the RAM enables.
module ram_queue_arbiter #(
  parameter int WORD_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_req,
  input  logic [WORD_W-1:0] push_data,
  output logic              push_ack,
  input  logic              pop_req,
  output logic              pop_ack,
  output logic              pop_valid,
  output logic [WORD_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_data_in,
  output logic              ram_enable_w,
  output logic              ram_enable_r,
  input  logic [WORD_W-1:0] ram_data_out
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, READ_WAIT} state_t;
  typedef enum logic {GRANT_POP, GRANT_PUSH} side_t;

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  state_t            state;
  side_t             last_grant;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_elig;
  logic              pop_elig;
  logic              grant_push;
  logic              grant_pop;

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign push_elig = push_req && !full;
  assign pop_elig  = pop_req && !empty;

  // last_grant only matters when both sides compete; solo grants leave it alone.
  always_comb begin
    grant_push = 1'b0;
    grant_pop  = 1'b0;
    if (push_elig && pop_elig) begin
      if (last_grant == GRANT_POP) grant_push = 1'b1;
      else                         grant_pop  = 1'b1;
    end else begin
      grant_push = push_elig;
      grant_pop  = pop_elig;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= GRANT_POP;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      push_ack     <= 1'b0;
      pop_ack      <= 1'b0;
      pop_valid    <= 1'b0;
      pop_data     <= '0;
      ram_addr     <= '0;
      ram_data_in  <= '0;
      ram_enable_w <= 1'b0;
      ram_enable_r <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (push_elig && pop_elig)
            last_grant <= grant_push ? GRANT_PUSH : GRANT_POP;
          if (grant_push) begin
            state        <= WRITE;
            push_ack     <= 1'b1;
            ram_enable_w <= 1'b1;
            ram_addr     <= wr_ptr;
            ram_data_in  <= push_data;
          end else if (grant_pop) begin
            state        <= READ;
            ram_enable_r <= 1'b1;
            ram_addr     <= rd_ptr;
          end
        end
        WRITE: begin
          state        <= IDLE;
          push_ack     <= 1'b0;
          ram_enable_w <= 1'b0;
          ram_addr     <= '0;
          ram_data_in  <= '0;
          wr_ptr       <= wr_ptr + 1'b1;
          count        <= count + 1'b1;
        end
        READ: begin
          // RAM registers the word on this edge; it appears on ram_data_out in READ_WAIT.
          state        <= READ_WAIT;
          ram_enable_r <= 1'b0;
          ram_addr     <= '0;
          pop_ack      <= 1'b1;
          rd_ptr       <= rd_ptr + 1'b1;
          count        <= count - 1'b1;
        end
        READ_WAIT: begin
          state     <= IDLE;
          pop_ack   <= 1'b0;
          pop_data  <= ram_data_out;
          pop_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
